uart_rx: RTL

UART receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It sits directly downstream of uart_tx on the serial line, or receives from an external host. It synchronises the asynchronous rx line, validates the start bit, samples each bit at mid-period and presents the received byte with a one-cycle valid strobe. Shares its bit-period convention with uart_tx, so the two loop back directly.

---
 rtl/uart_rx.sv | 112 +++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and one-cycle strobes
module uart_rx #(
    parameter int CLKS_PER_BIT = 105,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

    logic       rx_meta;
    logic       rx_s;
    logic       rx_s_d;
    logic [1:0] state;
    logic [15:0] counter;
    logic [2:0] bit_idx;
    logic [7:0] shift_reg;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // Frame state machine: start validation, data shifting, stop check
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            counter       <= 16'd0;
            bit_idx       <= 3'd0;
            shift_reg     <= 8'd0;
            data          <= 8'd0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    counter <= 16'd0;
                    // Only a high-to-low transition starts a frame; a stuck-low line does not
                    if (rx_s_d && !rx_s) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (counter == HALF_LAST) begin
                        counter <= 16'd0;
                        bit_idx <= 3'd0;
                        // Line back high at mid-start means a glitch, not a frame
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (counter == BIT_LAST) begin
                        counter   <= 16'd0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (counter == BIT_LAST) begin
                        counter <= 16'd0;
                        // Returning to IDLE at mid-stop lets a back-to-back start edge be seen
                        state   <= ST_IDLE;
                        if (rx_s) begin
                            data       <= shift_reg;
                            data_valid <= 1'b1;
                        end else begin
                            framing_error <= 1'b1;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    counter <= 16'd0;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
